alu_mc: RTL

//  Parametrised, registered ALU with a start/busy/done handshake. Single-cycle logic,

---
 rtl/alu_mc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Registered ALU with start/busy/done handshake: single-cycle logic/arith/shift/compare ops
// plus iterative unsigned multiply (shift-add) and divide (restoring) taking WIDTH steps.
module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic               zout_o,
    output logic               nout_o,
    output logic               vout_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   acc_q, mq_q, mcand_q;
    logic               isDiv_q;
    logic [WIDTH-1:0]   result_q, hi_q;
    logic               z_q, n_q, v_q, done_q;

    logic               accept, isIter;
    logic [WIDTH-1:0]   scRes;
    logic               scV;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH:0]     mulSum, divShift, divSub;
    logic               divGe;
    logic [WIDTH-1:0]   stepAcc, stepMq;

    assign accept = start_i && (state_q == IDLE);
    assign isIter = (op_i == 4'b1010) || (op_i == 4'b1011);
    assign sum    = a_i + b_i;
    assign diff   = a_i - b_i;

    always_comb begin
        scRes = '0;
        scV   = 1'b0;
        case (op_i)
            4'b0000: scRes = a_i & b_i;
            4'b0001: scRes = a_i | b_i;
            4'b0010: begin
                scRes = sum;
                scV   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'b0011: scRes = a_i;
            4'b0100: scRes = WIDTH'(a_i < b_i);
            4'b0101: scRes = b_i >> shamt_i;
            4'b0110: begin
                scRes = diff;
                scV   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'b0111: scRes = WIDTH'($signed(a_i) < $signed(b_i));
            4'b1000: scRes = b_i << shamt_i;
            4'b1001: scRes = $unsigned($signed(b_i) >>> shamt_i);
            default: scRes = '0;
        endcase
    end

    // acc holds the running product-high / partial remainder, mq the multiplier / quotient bits
    always_comb begin
        mulSum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
        divShift = {acc_q, mq_q[WIDTH-1]};
        divGe    = divShift >= {1'b0, mcand_q};
        divSub   = divShift - {1'b0, mcand_q};
        if (isDiv_q) begin
            stepAcc = divGe ? divSub[WIDTH-1:0] : divShift[WIDTH-1:0];
            stepMq  = {mq_q[WIDTH-2:0], divGe};
        end else begin
            stepAcc = mulSum[WIDTH:1];
            stepMq  = {mulSum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && isIter) state_d = RUN;
            RUN:     if (count_q == '0)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            mcand_q  <= '0;
            isDiv_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (isIter) begin
                    mcand_q <= b_i;
                    mq_q    <= a_i;
                    acc_q   <= '0;
                    isDiv_q <= op_i[0];
                    count_q <= CNT_W'(WIDTH - 1);
                end else begin
                    result_q <= scRes;
                    hi_q     <= '0;
                    z_q      <= (scRes == '0);
                    n_q      <= scRes[WIDTH-1];
                    v_q      <= scV;
                    done_q   <= 1'b1;
                end
            end else if (state_q == RUN) begin
                acc_q <= stepAcc;
                mq_q  <= stepMq;
                if (count_q == '0) begin
                    result_q <= stepMq;
                    hi_q     <= stepAcc;
                    z_q      <= (stepMq == '0);
                    n_q      <= stepMq[WIDTH-1];
                    v_q      <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign zout_o   = z_q;
    assign nout_o   = n_q;
    assign vout_o   = v_q;
    assign done_o   = done_q;

endmodule
